// File: rtl/apb_timer_master_if.sv
// Command/response and APB bus bundle for the timer APB requester.
// The master modport is the requester's view; slave is the environment's view.
interface apb_timer_master_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [3:0]        cmd_strb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_slverr;
   logic              rsp_timeout;
   logic              m_psel;
   logic              m_penable;
   logic              m_pwrite;
   logic [ADDR_W-1:0] m_paddr;
   logic [DATA_W-1:0] m_pwdata;
   logic [3:0]        m_pstrb;
   logic [DATA_W-1:0] m_prdata;
   logic              m_pready;
   logic              m_pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             m_prdata, m_pready, m_pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
             m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             m_prdata, m_pready, m_pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
             m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb
   );
endinterface

// File: rtl/apb_timer_master.sv
// Single-outstanding APB requester for the timer register port: one command in,
// one SETUP/ACCESS transfer out, one response back, with a wait-state timeout.
module apb_timer_master #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic                 sys_clk,
   input logic                 sys_rst_n,
   apb_timer_master_if.master  bus
);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [3:0]        r_pstrb;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_slverr;
   logic              r_rsp_timeout;
   logic              w_cmd_ready;

   assign w_cmd_ready     = (r_state == S_IDLE);
   assign bus.cmd_ready   = w_cmd_ready;
   assign bus.m_psel      = r_psel;
   assign bus.m_penable   = r_penable;
   assign bus.m_pwrite    = r_pwrite;
   assign bus.m_paddr     = r_paddr;
   assign bus.m_pwdata    = r_pwdata;
   assign bus.m_pstrb     = r_pstrb;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rsp_rdata;
   assign bus.rsp_slverr  = r_rsp_slverr;
   assign bus.rsp_timeout = r_rsp_timeout;

   // Transfer sequencer: APB phases, wait counting and response holding.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= {CNT_W{1'b0}};
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= {ADDR_W{1'b0}};
         r_pwdata      <= {DATA_W{1'b0}};
         r_pstrb       <= 4'h0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= {DATA_W{1'b0}};
         r_rsp_slverr  <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid && w_cmd_ready) begin
                  // Misaligned commands are answered locally without touching the bus.
                  if (bus.cmd_addr[1:0] != 2'b00) begin
                     r_state       <= S_RESP;
                     r_rsp_valid   <= 1'b1;
                     r_rsp_rdata   <= {DATA_W{1'b0}};
                     r_rsp_slverr  <= 1'b1;
                     r_rsp_timeout <= 1'b0;
                  end else begin
                     r_state   <= S_SETUP;
                     r_cnt     <= {CNT_W{1'b0}};
                     r_psel    <= 1'b1;
                     r_penable <= 1'b0;
                     r_pwrite  <= bus.cmd_write;
                     r_paddr   <= bus.cmd_addr;
                     r_pwdata  <= bus.cmd_wdata;
                     r_pstrb   <= bus.cmd_write ? bus.cmd_strb : 4'h0;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_SETUP: begin
               r_state   <= S_ACCESS;
               r_penable <= 1'b1;
            end
            S_ACCESS: begin
               if (bus.m_pready) begin
                  r_state       <= S_RESP;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= r_pwrite ? {DATA_W{1'b0}} : bus.m_prdata;
                  r_rsp_slverr  <= bus.m_pslverr;
                  r_rsp_timeout <= 1'b0;
               end else if ((TIMEOUT > 0) && (r_cnt == CNT_LAST)) begin
                  r_state       <= S_RESP;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= {DATA_W{1'b0}};
                  r_rsp_slverr  <= 1'b1;
                  r_rsp_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
               end else begin
                  r_state <= S_RESP;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_psel      <= 1'b0;
               r_penable   <= 1'b0;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb_timer_master.sv
// Directed plus randomized bench for apb_timer_master; expected timing and responses
// come from a transaction-level model of the requester's rules.
module tb_apb_timer_master;
   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   apb_timer_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_timer_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one command from a negedge, acts as the APB slave, then holds the
   // response for 'hold' cycles before consuming it. Returns at a negedge.
   task automatic run_txn(input string tag, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [3:0] st, input int waits,
                          input logic [31:0] rd, input logic se, input int hold);
      logic        mis;
      logic        to;
      int          exp_acc, exp_lat, cyc, n_setup, n_acc, bad;
      logic [31:0] exp_rdata;
      logic        exp_se;
      logic        got;
      logic [31:0] s_rdata;
      logic        s_se, s_to;
      mis       = (addr[1:0] != 2'b00);
      to        = !mis && (TIMEOUT > 0) && (waits >= TIMEOUT);
      exp_acc   = mis ? 0 : (to ? TIMEOUT : waits + 1);
      exp_lat   = mis ? 1 : 2 + exp_acc;
      exp_rdata = (mis || to || wr) ? 32'h0 : rd;
      exp_se    = mis || to || se;
      cyc = 0; n_setup = 0; n_acc = 0; bad = 0; got = 1'b0;

      check({tag, "_cmd_ready_idle"}, bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      bus.cmd_strb  = st;
      @(posedge clk);
      @(negedge clk);
      cyc = 1;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 12'($urandom);
      bus.cmd_wdata = $urandom;
      bus.cmd_strb  = 4'($urandom);
      bus.cmd_write = 1'($urandom);
      while (!got && cyc < 200) begin
         if (bus.rsp_valid) begin
            got = 1'b1;
         end else begin
            if (bus.m_psel && !bus.m_penable) n_setup++;
            if (bus.m_psel && bus.m_penable) n_acc++;
            if (bus.m_penable && !bus.m_psel) bad++;
            if (bus.m_psel && (bus.m_paddr !== addr || bus.m_pwrite !== wr ||
                               bus.m_pstrb !== (wr ? st : 4'h0) ||
                               (wr && bus.m_pwdata !== wd))) bad++;
            if (bus.cmd_ready) bad++;
            bus.m_pready  = bus.m_psel && bus.m_penable && (n_acc == waits + 1);
            bus.m_prdata  = bus.m_pready ? rd : $urandom;
            bus.m_pslverr = bus.m_pready ? se : 1'($urandom);
            @(negedge clk);
            cyc++;
         end
      end
      bus.m_pready = 1'b0;
      check({tag, "_rsp_seen"}, got, 1);
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_setup_cycles"}, n_setup, mis ? 0 : 1);
      check({tag, "_access_cycles"}, n_acc, exp_acc);
      check({tag, "_bus_protocol"}, bad, 0);
      check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
      check({tag, "_slverr"}, bus.rsp_slverr, exp_se);
      check({tag, "_timeout"}, bus.rsp_timeout, to);
      check({tag, "_idle_bus_at_rsp"}, {bus.m_psel, bus.m_penable, bus.cmd_ready}, 0);
      if (!mis) check({tag, "_paddr_kept"}, bus.m_paddr, addr);
      s_rdata = bus.rsp_rdata; s_se = bus.rsp_slverr; s_to = bus.rsp_timeout;
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== s_rdata || bus.rsp_slverr !== s_se ||
             bus.rsp_timeout !== s_to || bus.cmd_ready !== 1'b0 || bus.m_psel !== 1'b0) bad++;
      end
      if (hold > 0) check({tag, "_rsp_hold_stable"}, bad, 0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({tag, "_rsp_drop_after_hs"}, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
   endtask

   initial begin
      logic        r_wr;
      logic [11:0] r_addr;
      int          r_waits, sel;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 12'h000;
      bus.cmd_wdata = 32'h1234_5678;
      bus.cmd_strb  = 4'hF;
      bus.rsp_ready = 1'b0;
      bus.m_prdata  = 32'h0;
      bus.m_pready  = 1'b0;
      bus.m_pslverr = 1'b0;

      // Reset with a command pending: nothing may be captured.
      repeat (3) @(negedge clk);
      check("reset_outputs", {bus.m_psel, bus.m_penable, bus.rsp_valid, bus.rsp_slverr,
                              bus.rsp_timeout, bus.m_pwrite}, 0);
      check("reset_paddr", bus.m_paddr, 0);
      check("reset_cmd_ready", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      run_txn("t1_write", 1'b1, 12'h000, 32'h0000_0103, 4'hF, 0, 32'hA5A5_A5A5, 1'b0, 0);
      run_txn("t2_read_wait3", 1'b0, 12'h004, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 0);
      run_txn("t3_timeout", 1'b0, 12'h008, 32'h0, 4'h0, 1000, 32'h0, 1'b0, 0);
      run_txn("t4_misaligned", 1'b1, 12'h006, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b0, 0);
      run_txn("t5_backpressure", 1'b0, 12'h00C, 32'h0, 4'h3, 1, 32'h1357_9BDF, 1'b1, 5);
      run_txn("t5_next_cmd", 1'b1, 12'h010, 32'hCAFE_F00D, 4'h5, 0, 32'h0, 1'b0, 0);
      run_txn("ready_beats_timeout", 1'b0, 12'h014, 32'h0, 4'h0, TIMEOUT - 1,
              32'h0BAD_F00D, 1'b0, 0);

      // Reset in the middle of an ACCESS phase.
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 12'h018;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_in_access", {bus.m_psel, bus.m_penable}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("t6_async_drop", {bus.m_psel, bus.m_penable, bus.rsp_valid, bus.cmd_ready}, 4'b0001);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_after_release", {bus.m_psel, bus.rsp_valid, bus.cmd_ready}, 3'b001);
      run_txn("t6_recover", 1'b0, 12'h01C, 32'h0, 4'h0, 2, 32'h7777_0001, 1'b0, 1);

      for (int n = 0; n < 24; n++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_addr = {10'($urandom_range(0, 1023)), 2'b00};
         if ($urandom_range(0, 7) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
         sel = $urandom_range(0, 9);
         if (sel < 7)       r_waits = $urandom_range(0, 4);
         else if (sel == 7) r_waits = TIMEOUT - 1;
         else if (sel == 8) r_waits = TIMEOUT;
         else               r_waits = $urandom_range(TIMEOUT + 1, TIMEOUT + 9);
         run_txn($sformatf("rnd%0d", n), r_wr, r_addr, $urandom, 4'($urandom), r_waits,
                 $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
